// File: rtl/seven_segment_mux.sv
// Multiplexed hex seven-segment driver: scans DIGITS digits one slot at a time,
// blanks the anodes for BLANK cycles at the start of each slot, and double-buffers
// the displayed value so an update only takes effect between frames.
// Optional feature: define SEVSEG_ZERO_BLANK_EN to suppress leading zero digits.
module seven_segment_mux #(
  parameter int DIGITS = 4,
  parameter int COUNT  = 500_000,
  parameter int BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   word,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [7:0]            anode_activate,
  output logic                  frame_done
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);

  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic                pending_q, pending_d;
  logic [4*DIGITS-1:0] staging_word_q, staging_word_d;
  logic [DIGITS-1:0]   staging_dp_q, staging_dp_d;
  logic [4*DIGITS-1:0] shadow_word_q, shadow_word_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_out_q, dp_out_d;
  logic [7:0]          anode_q, anode_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_end;
  logic [DIGITS-1:0]   lit;
  logic [3:0]          nib;
  logic                dp_sel;
  logic                en_sel;

  // Active-high abcdefg pattern for a hex nibble; inverted later for the active-low pins.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1111110;
      4'h1: hex_glyph = 7'b0110000;
      4'h2: hex_glyph = 7'b1101101;
      4'h3: hex_glyph = 7'b1111001;
      4'h4: hex_glyph = 7'b0110011;
      4'h5: hex_glyph = 7'b1011011;
      4'h6: hex_glyph = 7'b1011111;
      4'h7: hex_glyph = 7'b1110000;
      4'h8: hex_glyph = 7'b1111111;
      4'h9: hex_glyph = 7'b1111011;
      4'hA: hex_glyph = 7'b1110111;
      4'hB: hex_glyph = 7'b0011111;
      4'hC: hex_glyph = 7'b1001110;
      4'hD: hex_glyph = 7'b0111101;
      4'hE: hex_glyph = 7'b1001111;
      default: hex_glyph = 7'b1000111;
    endcase
  endfunction

  // Slot timing, digit index advance and the staging/shadow double buffer.
  always_comb begin
    frame_end      = (counter_q == CNT_LAST) && (index_q == IDX_LAST);
    counter_d      = counter_q + CNT_W'(1);
    index_d        = index_q;
    pending_d      = pending_q;
    staging_word_d = staging_word_q;
    staging_dp_d   = staging_dp_q;
    shadow_word_d  = shadow_word_q;
    shadow_dp_d    = shadow_dp_q;
    if (counter_q == CNT_LAST) begin
      counter_d = '0;
      index_d   = (index_q == IDX_LAST) ? '0 : index_q + IDX_W'(1);
    end
    if (frame_end) begin
      if (load) begin
        shadow_word_d = word;
        shadow_dp_d   = dp;
      end else if (pending_q) begin
        shadow_word_d = staging_word_q;
        shadow_dp_d   = staging_dp_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      staging_word_d = word;
      staging_dp_d   = dp;
      pending_d      = 1'b1;
    end
  end

`ifdef SEVSEG_ZERO_BLANK_EN
  logic seen_nonzero;

  // Light only digits at or below the most significant nonzero nibble; digit 0 always lit.
  always_comb begin
    lit          = '0;
    seen_nonzero = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_nonzero = seen_nonzero | (shadow_word_d[4*i +: 4] != 4'h0);
      lit[i]       = seen_nonzero | (i == 0);
    end
  end
`else
  assign lit = '1;
`endif

  // Output drive for the cycle being entered, so the registered pins match counter/index.
  always_comb begin
    nib          = 4'h0;
    dp_sel       = 1'b0;
    en_sel       = 1'b0;
    anode_d      = 8'hFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (index_d == IDX_W'(i)) begin
        nib    = shadow_word_d[4*i +: 4];
        dp_sel = shadow_dp_d[i];
        en_sel = digit_en[i] & lit[i];
        if (digit_en[i] && lit[i] && (counter_d >= BLANK_C)) begin
          anode_d[i] = 1'b0;
        end
      end
    end
    seg_d        = en_sel ? ~hex_glyph(nib) : 7'h7F;
    dp_out_d     = en_sel ? ~dp_sel : 1'b1;
    frame_done_d = (counter_d == CNT_LAST) && (index_d == IDX_LAST);
  end

  // State and output registers; reset drops any pending load and darkens the display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q      <= '0;
      index_q        <= '0;
      pending_q      <= 1'b0;
      staging_word_q <= '0;
      staging_dp_q   <= '0;
      shadow_word_q  <= '0;
      shadow_dp_q    <= '0;
      seg_q          <= 7'h7F;
      dp_out_q       <= 1'b1;
      anode_q        <= 8'hFF;
      frame_done_q   <= 1'b0;
    end else begin
      counter_q      <= counter_d;
      index_q        <= index_d;
      pending_q      <= pending_d;
      staging_word_q <= staging_word_d;
      staging_dp_q   <= staging_dp_d;
      shadow_word_q  <= shadow_word_d;
      shadow_dp_q    <= shadow_dp_d;
      seg_q          <= seg_d;
      dp_out_q       <= dp_out_d;
      anode_q        <= anode_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign seg            = seg_q;
  assign dp_out         = dp_out_q;
  assign anode_activate = anode_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed scoreboard bench for seven_segment_mux with DIGITS=4, COUNT=4, BLANK=1.
// Cycle k after reset release is slot k/4, counter k%4; expected pin values are
// queued per cycle and compared on the falling edge.
module tb_seven_segment_mux;

  localparam int DIGITS = 4;
  localparam int COUNT  = 4;
  localparam int BLANK  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] word;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        load;
  logic [6:0]  seg;
  logic        dp_out;
  logic [7:0]  anode_activate;
  logic        frame_done;

  typedef struct {
    string      tag;
    int         k;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] anode;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   push_k = 1;

  seven_segment_mux #(.DIGITS(DIGITS), .COUNT(COUNT), .BLANK(BLANK)) dut (
    .clk            (clk),
    .reset          (reset),
    .word           (word),
    .dp             (dp),
    .digit_en       (digit_en),
    .load           (load),
    .seg            (seg),
    .dp_out         (dp_out),
    .anode_activate (anode_activate),
    .frame_done     (frame_done)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1111110;  4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;  4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;  4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;  4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;  4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;  4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;  4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;  default: glyph = 7'b1000111;
    endcase
  endfunction

  task automatic applyStimulus(input logic [15:0] w, input logic [3:0] d,
                               input logic [3:0] en, input logic ld);
    word     = w;
    dp       = d;
    digit_en = en;
    load     = ld;
  endtask

  // Queue what the pins should show for the next n cycles given the displayed value.
  task automatic pushStates(input string tag, input logic [15:0] w, input logic [3:0] d,
                            input logic [3:0] en, input int n);
    for (int j = 0; j < n; j++) begin
      exp_t e;
      int   c;
      int   idx;
      bit   on;
      c   = push_k % COUNT;
      idx = (push_k / COUNT) % DIGITS;
      on  = en[idx];
`ifdef SEVSEG_ZERO_BLANK_EN
      if (idx != 0 && (w >> (4 * idx)) == 16'h0) on = 1'b0;
`endif
      e.tag   = tag;
      e.k     = push_k;
      e.anode = (c < BLANK || !on) ? 8'hFF : ~(8'h01 << idx);
      e.seg   = on ? ~glyph(w[4*idx +: 4]) : 7'h7F;
      e.dp    = on ? ~d[idx] : 1'b1;
      e.fd    = (c == COUNT - 1) && (idx == DIGITS - 1);
      exp_q.push_back(e);
      push_k++;
    end
  endtask

  task automatic checkField(input string tag, input string field, input int k,
                            input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("[TB] FAIL %s.%s cycle %0d: observed %h expected %h", tag, field, k, got, want);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("[TB] FAIL scoreboard_underflow: observed empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      checkField(e.tag, "seg",   e.k, {1'b0, seg}, {1'b0, e.seg});
      checkField(e.tag, "dp",    e.k, {7'b0, dp_out}, {7'b0, e.dp});
      checkField(e.tag, "anode", e.k, anode_activate, e.anode);
      checkField(e.tag, "fd",    e.k, {7'b0, frame_done}, {7'b0, e.fd});
    end
  endtask

  task automatic checkReset(input string tag);
    checkField(tag, "seg",   0, {1'b0, seg}, 8'h7F);
    checkField(tag, "dp",    0, {7'b0, dp_out}, 8'h01);
    checkField(tag, "anode", 0, anode_activate, 8'hFF);
    checkField(tag, "fd",    0, {7'b0, frame_done}, 8'h00);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    for (int j = 0; j < n; j++) stepCycle();
  endtask

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence: load, mid-frame load, pending vs direct load, enables, reset.
  initial begin
    reset = 1'b1;
    applyStimulus(16'h0000, 4'h0, 4'hF, 1'b0);
    repeat (3) @(negedge clk);
    checkReset("reset_hold");
    reset = 1'b0;
    checkReset("first_slot");
    push_k = 1;

    applyStimulus(16'h12AF, 4'b0001, 4'hF, 1'b1);
    pushStates("pre_load", 16'h0000, 4'h0, 4'hF, 15);
    stepCycle();
    load = 1'b0;
    runCycles(14);

    pushStates("frame_12AF", 16'h12AF, 4'b0001, 4'hF, 16);
    runCycles(2);
    applyStimulus(16'h3333, 4'h0, 4'hF, 1'b1);
    stepCycle();
    load = 1'b0;
    runCycles(13);

    pushStates("frame_3333", 16'h3333, 4'h0, 4'hF, 16);
    runCycles(8);
    applyStimulus(16'h5555, 4'hF, 4'hF, 1'b1);
    stepCycle();
    load = 1'b0;
    runCycles(7);
    applyStimulus(16'h6789, 4'b1010, 4'hF, 1'b1);
    pushStates("direct_wins", 16'h6789, 4'b1010, 4'hF, 16);
    pushStates("pending_clear", 16'h6789, 4'b1010, 4'hF, 16);
    stepCycle();
    load = 1'b0;
    runCycles(31);

    applyStimulus(16'h6789, 4'b1010, 4'b0101, 1'b0);
    pushStates("en_0101", 16'h6789, 4'b1010, 4'b0101, 16);
    runCycles(16);

    applyStimulus(16'h0070, 4'h0, 4'hF, 1'b1);
    pushStates("word_0070", 16'h0070, 4'h0, 4'hF, 16);
    stepCycle();
    load = 1'b0;
    runCycles(15);

    pushStates("pre_reset", 16'h0070, 4'h0, 4'hF, 3);
    runCycles(2);
    applyStimulus(16'hBEEF, 4'hF, 4'hF, 1'b1);
    stepCycle();
    load  = 1'b0;
    reset = 1'b1;
    #1;
    checkReset("async_reset");
    @(negedge clk);
    reset = 1'b0;
    checkReset("post_reset");
    push_k = 1;
    pushStates("discard_pending", 16'h0000, 4'h0, 4'hF, 19);
    runCycles(19);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("[TB] FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_mux.md
SEVEN_SEGMENT_MUX -- requirements
Module: seven_segment_mux

Interface
REQ-001 The module SHALL have parameter DIGITS, default 4: number of multiplexed hex digits, legal range 1..8.
REQ-002 The module SHALL have parameter COUNT, default 500_000: clk cycles per digit slot, legal range ≥2.
REQ-003 The module SHALL have parameter BLANK, default 16: anode-off guard cycles at the start of each slot, legal range 0..COUNT-1.
REQ-004 The module SHALL have one clock and asynchronous active-high reset, named as follows: clk input 1 (rising-edge clock); reset input 1 (asynchronous, active-high reset).
REQ-005 The module SHALL have input word, width 4*DIGITS: hex nibbles, with digit i at word[4i+3:4i].
REQ-006 The module SHALL have input dp, width DIGITS: decimal point request, one bit per digit, active-high.
REQ-007 The module SHALL have input digit_en, width DIGITS: per-digit enable; 0 keeps that digit dark.
REQ-008 The module SHALL have input load, width 1: single-cycle strobe that stages word and dp for display.
REQ-009 The module SHALL have output seg, width 7: segment drive {a..g} = seg[6:0], active-low.
REQ-010 The module SHALL have output dp_out, width 1: decimal point drive, active-low.
REQ-011 The module SHALL have output anode_activate, width 8: digit select, active-low.
REQ-012 The module SHALL have output frame_done, width 1: one-cycle pulse at the end of each full scan.

Function
REQ-013 The module SHALL run all logic on clk only, with no derived clocks; slot timing SHALL come from a counter running 0..COUNT-1.
REQ-014 When the counter equals COUNT-1, the next edge SHALL reset the counter to 0 and advance the digit index, wrapping from DIGITS-1 to 0.
REQ-015 Registered outputs seg, dp_out and anode_activate SHALL reflect the digit index and counter value of the current cycle.
REQ-016 During counter < BLANK, anode_activate SHALL be 8'hFF; during counter ≥ BLANK, bit[index] SHALL be 0 if digit_en[index]=1, and all other bits SHALL be 1.
REQ-017 seg SHALL show the hex glyph (0-9, A, b, C, d, E, F) of shadow nibble[index]; dp_out SHALL be the inverse of shadow dp[index].
REQ-018 A disabled digit SHALL still consume its slot; seg SHALL be 7'h7F and dp_out SHALL be 1 for that slot.
REQ-019 anode_activate bits DIGITS..7 SHALL be held at 1 at all times.
REQ-020 On load=1, word and dp SHALL be captured into staging registers and a pending flag SHALL be set.
REQ-021 If load repeats while pending, the staging registers SHALL take the latest values.
REQ-022 At frame end (counter=COUNT-1 and index=DIGITS-1): if pending, the shadow SHALL be updated from staging and pending cleared; if load=1 in that same cycle, the shadow SHALL take word and dp directly and pending SHALL end clear.
REQ-023 The shadow SHALL never change mid-frame, so there is no tearing.
REQ-024 frame_done SHALL be 1 exactly in the frame-end cycle.
REQ-025 With DIGITS=1, the index SHALL stay 0 and frame_done SHALL pulse every COUNT cycles.

Reset
REQ-026 Asserting reset at any time SHALL immediately force: counter 0, index 0, pending 0, staging and shadow 0, seg 7'h7F, dp_out 1, anode_activate 8'hFF, frame_done 0.
REQ-027 After reset deasserts, the first cycle SHALL be counter 0 of slot 0.
REQ-028 A reset asserted mid-frame SHALL discard any pending load.

Configuration
REQ-029 With macro SEVSEG_ZERO_BLANK_EN defined, digits above the most-significant nonzero shadow nibble SHALL be treated as disabled (seg 7'h7F, anode off, dp forced off), and digit 0 SHALL always be shown.
REQ-030 Without SEVSEG_ZERO_BLANK_EN, only digit_en SHALL gate digits; leading zeros SHALL display as "0".

Verification (DIGITS=4, COUNT=4, BLANK=1)
REQ-031 Stimulus: reset, then load word=16'h12AF, dp=4'b0001, digit_en=4'hF. Required response: after the first frame_done, slot0 shows seg=~7'b1000111 and dp_out=0, and anode_activate=8'hFE for 3 of 4 cycles.
REQ-032 Stimulus: scan 16 cycles after the shadow updates. Required response: anode_activate sequence per slot is FF,FE,FE,FE / FF,FD,FD,FD / FF,FB,FB,FB / FF,F7,F7,F7, and frame_done pulses every 16 cycles.
REQ-033 Stimulus: load 16'h3333 mid-frame. Required response: glyphs stay 12AF until frame end, then all slots show ~7'b1111001.
REQ-034 Stimulus: load asserted in the frame-end cycle together with an earlier pending load. Required response: the direct word wins, and pending reads 0 afterward.
REQ-035 Stimulus: digit_en=4'b0101. Required response: slots 1 and 3 show anode 8'hFF and seg 7'h7F throughout, and timing is unchanged.
REQ-036 Stimulus: word=16'h0070 with SEVSEG_ZERO_BLANK_EN defined. Required response: digits 2 and 3 are dark. Without the macro, they show ~7'b1111110.
